// File: rtl/bg_tile_fetcher.sv
// rtl/bg_tile_fetcher.sv - background tile row prefetcher and per-pixel tile lookup
//
// Purpose:
//   When line_start pulses, the front and back line buffers swap. The block then
//   prefetches one tile row (16 indices, stored as 4 words) from the background
//   index memory into the back line buffer. In parallel it answers per-pixel
//   lookups from the front line buffer, with a 1-cycle registered latency.
//
// Optional feature macro: BG_SCROLL_EN
//   When defined, the scroll_x/scroll_y inputs are present. Both coordinates
//   wrap modulo 512.
//
// Ports:
//   clk, reset_n                  clock, synchronous active-low reset
//   line_start, line_y            prefetch trigger and the line to prefetch
//   pix_valid, pix_x              per-pixel lookup request
//   mem_address/chipselect/clken  index memory read interface (read-only)
//   mem_readdata                  index memory data, one cycle after address
//   tile_valid/idx/px/py          lookup result
//   fetch_busy, overrun           prefetch status; overrun is sticky
//   scroll_x, scroll_y            (BG_SCROLL_EN only) map scroll offsets
module bg_tile_fetcher #(
  parameter int          TILE_SHIFT = 5,
  parameter logic [7:0]  BLANK_IDX  = 8'h00,
  parameter int          COORD_W    = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  line_start,
  input  logic [COORD_W-1:0]    line_y,
  input  logic                  pix_valid,
  input  logic [COORD_W-1:0]    pix_x,
`ifdef BG_SCROLL_EN
  input  logic [8:0]            scroll_x,
  input  logic [8:0]            scroll_y,
`endif
  output logic [5:0]            mem_address,
  output logic                  mem_chipselect,
  output logic                  mem_clken,
  input  logic [31:0]           mem_readdata,
  output logic                  tile_valid,
  output logic [7:0]            tile_idx,
  output logic [TILE_SHIFT-1:0] tile_px,
  output logic [TILE_SHIFT-1:0] tile_py,
  output logic                  fetch_busy,
  output logic                  overrun
);

  localparam int CW = COORD_W - TILE_SHIFT;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                state_q;
  logic [1:0]            k_q;
  logic [3:0]            row_q;
  logic                  front_sel_q;
  logic [TILE_SHIFT-1:0] front_py_q;
  logic [TILE_SHIFT-1:0] back_py_q;
  logic [7:0]            buf_q [2][16];
  logic [5:0]            mem_address_q;
  logic                  mem_cs_q;
  logic                  busy_q;
  logic                  overrun_q;
  logic                  tile_valid_q;
  logic [7:0]            tile_idx_q;
  logic [TILE_SHIFT-1:0] tile_px_q;
  logic [TILE_SHIFT-1:0] tile_py_q;

  logic [COORD_W-1:0]    eff_x;
  logic [COORD_W-1:0]    eff_y;

`ifdef BG_SCROLL_EN
  logic [8:0] scroll_x_q;
  logic [8:0] x_sum;
  logic [8:0] y_sum;
  // 9-bit sums wrap modulo 512, so the map repeats in both directions.
  assign x_sum = pix_x[8:0] + scroll_x_q;
  assign y_sum = line_y[8:0] + scroll_y;
  assign eff_x = COORD_W'(x_sum);
  assign eff_y = COORD_W'(y_sum);
`else
  assign eff_x = pix_x;
  assign eff_y = line_y;
`endif

  logic [CW-1:0] tile_row;
  logic [CW-1:0] tile_col;
  logic          row_in_map;
  logic          col_in_map;
  assign tile_row   = eff_y[COORD_W-1:TILE_SHIFT];
  assign tile_col   = eff_x[COORD_W-1:TILE_SHIFT];
  assign row_in_map = (tile_row < CW'(16));
  assign col_in_map = (tile_col < CW'(16));

  // The word whose address went out last cycle arrives now. This is word k-1
  // while in FETCH, or the final word 3 while in DRAIN.
  logic       cap_en;
  logic [1:0] cap_k;
  assign cap_en = ((state_q == FETCH) && (k_q != 2'd0)) || (state_q == DRAIN);
  assign cap_k  = (state_q == DRAIN) ? 2'd3 : (k_q - 2'd1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      k_q           <= '0;
      row_q         <= '0;
      front_sel_q   <= 1'b0;
      front_py_q    <= '0;
      back_py_q     <= '0;
      mem_address_q <= '0;
      mem_cs_q      <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      tile_valid_q  <= 1'b0;
      tile_idx_q    <= '0;
      tile_px_q     <= '0;
      tile_py_q     <= '0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < 16; i++)
          buf_q[b][i] <= BLANK_IDX;
`ifdef BG_SCROLL_EN
      scroll_x_q    <= '0;
`endif
    end else begin
      // Lookup path. This reads the pre-swap front buffer, even in a line_start cycle.
      tile_valid_q <= pix_valid;
      if (pix_valid) begin
        tile_idx_q <= col_in_map ? buf_q[front_sel_q][tile_col[3:0]] : BLANK_IDX;
        tile_px_q  <= eff_x[TILE_SHIFT-1:0];
        tile_py_q  <= front_py_q;
      end

      if (line_start) begin
        // Swap the buffers. A fetch still in flight is abandoned, so a
        // partially filled buffer becomes the front buffer.
        front_sel_q <= ~front_sel_q;
        front_py_q  <= back_py_q;
        back_py_q   <= eff_y[TILE_SHIFT-1:0];
`ifdef BG_SCROLL_EN
        scroll_x_q  <= scroll_x;
`endif
        if (busy_q)
          overrun_q <= 1'b1;
        if (row_in_map) begin
          state_q       <= FETCH;
          k_q           <= 2'd0;
          row_q         <= tile_row[3:0];
          mem_address_q <= {tile_row[3:0], 2'd0};
          mem_cs_q      <= 1'b1;
          busy_q        <= 1'b1;
        end else begin
          // After the swap, the new back buffer is the old front buffer.
          state_q  <= IDLE;
          mem_cs_q <= 1'b0;
          busy_q   <= 1'b0;
          for (int i = 0; i < 16; i++)
            buf_q[front_sel_q][i] <= BLANK_IDX;
        end
      end else begin
        if (cap_en)
          for (int j = 0; j < 4; j++)
            buf_q[~front_sel_q][{cap_k, 2'(j)}] <= mem_readdata[8*j +: 8];
        case (state_q)
          FETCH: begin
            if (k_q == 2'd3) begin
              state_q  <= DRAIN;
              mem_cs_q <= 1'b0;
            end else begin
              k_q           <= k_q + 2'd1;
              mem_address_q <= {row_q, k_q + 2'd1};
            end
          end
          DRAIN: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign mem_address    = mem_address_q;
  assign mem_chipselect = mem_cs_q;
  assign mem_clken      = reset_n;
  assign fetch_busy     = busy_q;
  assign overrun        = overrun_q;
  assign tile_valid     = tile_valid_q;
  assign tile_idx       = tile_idx_q;
  assign tile_px        = tile_px_q;
  assign tile_py        = tile_py_q;

endmodule

// File: tb/tb_bg_tile_fetcher.sv
// tb/tb_bg_tile_fetcher.sv - directed self-checking bench for bg_tile_fetcher
module tb_bg_tile_fetcher;

  logic        clk;
  logic        reset_n;
  logic        line_start;
  logic [9:0]  line_y;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [8:0]  scroll_x;
  logic [8:0]  scroll_y;
  logic [5:0]  mem_address;
  logic        mem_chipselect;
  logic        mem_clken;
  logic [31:0] mem_readdata;
  logic        tile_valid;
  logic [7:0]  tile_idx;
  logic [4:0]  tile_px;
  logic [4:0]  tile_py;
  logic        fetch_busy;
  logic        overrun;

  logic [31:0] mem [64];

  int n_vec = 0;
  int n_err = 0;

  bg_tile_fetcher dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .line_start     (line_start),
    .line_y         (line_y),
    .pix_valid      (pix_valid),
    .pix_x          (pix_x),
`ifdef BG_SCROLL_EN
    .scroll_x       (scroll_x),
    .scroll_y       (scroll_y),
`endif
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata),
    .tile_valid     (tile_valid),
    .tile_idx       (tile_idx),
    .tile_px        (tile_px),
    .tile_py        (tile_py),
    .fetch_busy     (fetch_busy),
    .overrun        (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_chipselect && mem_clken)
      mem_readdata <= mem[mem_address];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (fetch_busy && n < 50) begin
      tick();
      n++;
    end
    check("idle_wait", 32'(fetch_busy), 32'd0);
  endtask

  task automatic pulse_line(input logic [9:0] y);
    line_start = 1'b1;
    line_y     = y;
    tick();
    line_start = 1'b0;
  endtask

  task automatic lookup(input logic [9:0] x);
    pix_valid = 1'b1;
    pix_x     = x;
    tick();
  endtask

  initial begin
    int cnt;
    for (int w = 0; w < 64; w++)
      for (int j = 0; j < 4; j++)
        mem[w][8*j +: 8] = 8'h80 | 8'(4*w + j);
    mem[4] = 32'h04030201;
    mem[7] = 32'h100F0E0D;
    mem_readdata = 32'h0;
    reset_n = 1'b0; line_start = 1'b0; line_y = '0;
    pix_valid = 1'b0; pix_x = '0; scroll_x = '0; scroll_y = '0;

    // Reset state
    tick(); tick();
    check("rst_valid", 32'(tile_valid), 32'd0);
    check("rst_idx", 32'(tile_idx), 32'd0);
    check("rst_busy", 32'(fetch_busy), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    check("rst_cs", 32'(mem_chipselect), 32'd0);
    check("rst_addr", 32'(mem_address), 32'd0);
    check("rst_clken", 32'(mem_clken), 32'd0);
    reset_n = 1'b1;
    tick();
    check("clken_run", 32'(mem_clken), 32'd1);

    // A basic fetch, then a swap, then lookups
    pulse_line(10'd37);
    check("t1_addr0", 32'(mem_address), 32'd4);
    check("t1_cs", 32'(mem_chipselect), 32'd1);
    cnt = 0;
    while (fetch_busy && cnt < 20) begin
      cnt++;
      tick();
    end
    check("t1_busy_len", 32'(cnt), 32'd5);
    pulse_line(10'd38);
    lookup(10'd0);
    check("t1_valid", 32'(tile_valid), 32'd1);
    check("t1_idx_x0", 32'(tile_idx), 32'h01);
    check("t1_py", 32'(tile_py), 32'd5);
    lookup(10'd32);
    check("t1_idx_x32", 32'(tile_idx), 32'h02);
    lookup(10'd37);
    check("t1_idx_x37", 32'(tile_idx), 32'h02);
    check("t1_px_x37", 32'(tile_px), 32'd5);
    lookup(10'd480);
    check("t1_idx_x480", 32'(tile_idx), 32'h10);
    pix_valid = 1'b0; pix_x = 10'd0;
    tick();
    check("t1_nvalid", 32'(tile_valid), 32'd0);
    check("t1_hold", 32'(tile_idx), 32'h10);
    wait_idle();

    // A line_start arrives while a fetch is in progress
    pulse_line(10'd64);
    check("t2_addr8", 32'(mem_address), 32'd8);
    tick();
    check("t2_addr9", 32'(mem_address), 32'd9);
    check("t2_ovr0", 32'(overrun), 32'd0);
    pulse_line(10'd96);
    check("t2_restart", 32'(mem_address), 32'd12);
    check("t2_ovr1", 32'(overrun), 32'd1);
    check("t2_busy", 32'(fetch_busy), 32'd1);
    wait_idle();
    check("t2_ovr_sticky", 32'(overrun), 32'd1);

    // Out-of-map row and out-of-map column
    pulse_line(10'd600);
    check("t3_busy", 32'(fetch_busy), 32'd0);
    check("t3_cs", 32'(mem_chipselect), 32'd0);
    pulse_line(10'd0);
    check("t3_cs_row0", 32'(mem_chipselect), 32'd1);
    lookup(10'd100);
    check("t3_blank_row", 32'(tile_idx), 32'h00);
    check("t3_py", 32'(tile_py), 32'd24);
    check("t3_px", 32'(tile_px), 32'd4);
    pix_valid = 1'b0;
    wait_idle();
    pulse_line(10'd3);
    lookup(10'd64);
    check("t3_row0_c2", 32'(tile_idx), 32'h82);
    lookup(10'd700);
    check("t3_blank_col", 32'(tile_idx), 32'h00);
    check("t3_px700", 32'(tile_px), 32'd28);
    check("t3_py0", 32'(tile_py), 32'd0);
    pix_valid = 1'b0;
    wait_idle();

    // A lookup in the same cycle as line_start uses the old front buffer
    pulse_line(10'd40);
    wait_idle();
    line_start = 1'b1; line_y = 10'd0;
    pix_valid = 1'b1; pix_x = 10'd0;
    tick();
    line_start = 1'b0;
    check("t4_old_idx", 32'(tile_idx), 32'h80);
    check("t4_old_py", 32'(tile_py), 32'd3);
    tick();
    check("t4_new_idx", 32'(tile_idx), 32'h01);
    check("t4_new_py", 32'(tile_py), 32'd8);
    pix_valid = 1'b0;
    wait_idle();

    // Reset in the middle of a fetch
    pulse_line(10'd32);
    tick(); tick();
    check("t5_addr6", 32'(mem_address), 32'd6);
    reset_n = 1'b0;
    tick();
    check("t5_busy", 32'(fetch_busy), 32'd0);
    check("t5_cs", 32'(mem_chipselect), 32'd0);
    reset_n = 1'b1;
    lookup(10'd0);
    check("t5_valid", 32'(tile_valid), 32'd1);
    check("t5_blank0", 32'(tile_idx), 32'h00);
    lookup(10'd32);
    check("t5_blank1", 32'(tile_idx), 32'h00);
    pix_valid = 1'b0;
    pulse_line(10'd32);
    wait_idle();
    pulse_line(10'd33);
    lookup(10'd0);
    check("t5_refill", 32'(tile_idx), 32'h01);
    check("t5_py", 32'(tile_py), 32'd0);
    pix_valid = 1'b0;
    wait_idle();

`ifdef BG_SCROLL_EN
    // Scroll offsets wrap modulo 512
    scroll_x = 9'd500; scroll_y = 9'd510;
    pulse_line(10'd4);
    check("t6_addr_row0", 32'(mem_address), 32'd0);
    wait_idle();
    pulse_line(10'd4);
    lookup(10'd20);
    check("t6_idx", 32'(tile_idx), 32'h80);
    check("t6_px", 32'(tile_px), 32'd8);
    check("t6_py", 32'(tile_py), 32'd2);
    pix_valid = 1'b0;
    wait_idle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
